// File: rtl/store_buffer_fwd_pkg.sv
// Shared definitions for the MEM-stage store buffer: FSM encodings and default widths.
package store_buffer_fwd_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DEPTH  = 4;

  typedef enum logic [1:0] {
    FSM_IDLE  = 2'd0,
    FSM_DRAIN = 2'd1,
    FSM_DONE  = 2'd2
  } fsm_e;

endpackage

// File: rtl/store_buffer_fwd_match.sv
// Youngest-match search over the store buffer entries, scanning backwards from the tail.
module stbuf_match #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32
) (
  input  logic [DEPTH-1:0]             valid_i,
  input  logic [DEPTH-1:0][ADDR_W-1:0] addr_i,
  input  logic [$clog2(DEPTH)-1:0]     tail_i,
  input  logic [ADDR_W-1:0]            ld_addr_i,
  output logic                         hit_o,
  output logic [$clog2(DEPTH)-1:0]     idx_o
);

  localparam int IDX_W = $clog2(DEPTH);

  // Oldest candidate first so the entry just behind the tail overrides everything else.
  always_comb begin
    hit_o = 1'b0;
    idx_o = {IDX_W{1'b0}};
    for (int k = DEPTH; k >= 1; k--) begin
      if (valid_i[tail_i - IDX_W'(k)] && (addr_i[tail_i - IDX_W'(k)] == ld_addr_i)) begin
        hit_o = 1'b1;
        idx_o = tail_i - IDX_W'(k);
      end else begin
        hit_o = hit_o;
        idx_o = idx_o;
      end
    end
  end

endmodule

// File: rtl/store_buffer_fwd.sv
// MEM-stage store buffer: FIFO drain to data memory, youngest-store load forwarding, flush handshake.
// Optional build macro STBUF_COALESCE_EN merges a store into the youngest entry on an address match.
module store_buffer_fwd
  import store_buffer_fwd_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DEPTH  = DEF_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     st_valid,
  input  logic [ADDR_W-1:0]        st_addr,
  input  logic [DATA_W-1:0]        st_data,
  output logic                     st_ready,
  input  logic                     ld_valid,
  input  logic [ADDR_W-1:0]        ld_addr,
  output logic                     ld_hit,
  output logic [DATA_W-1:0]        ld_data,
  output logic                     mem_wr_valid,
  output logic [ADDR_W-1:0]        mem_wr_addr,
  output logic [DATA_W-1:0]        mem_wr_data,
  input  logic                     mem_wr_ready,
  input  logic                     flush_req,
  output logic                     flush_done,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = IDX_W + 1;

  logic [DEPTH-1:0]             valid_q, valid_d;
  logic [DEPTH-1:0][ADDR_W-1:0] addr_q, addr_d;
  logic [DEPTH-1:0][DATA_W-1:0] data_q, data_d;
  logic [IDX_W-1:0]             head_q, head_d;
  logic [IDX_W-1:0]             tail_q, tail_d;
  logic [CNT_W-1:0]             count_q, count_d;
  fsm_e                         state_q, state_d;

  logic             empty_s, full_s, pop_s, last_pop_s, coal_s;
  logic             acc_s, alloc_s, merge_s;
  logic [IDX_W-1:0] youngest_s;
  logic             hit_s;
  logic [IDX_W-1:0] hit_idx_s;

  assign empty_s    = (count_q == CNT_W'(0));
  assign full_s     = (count_q == CNT_W'(DEPTH));
  assign pop_s      = !empty_s && mem_wr_ready;
  assign last_pop_s = (count_q == CNT_W'(1)) && pop_s;
  assign youngest_s = tail_q - IDX_W'(1);

  // A merge into a head that is leaving this cycle would be lost, so it allocates instead.
`ifdef STBUF_COALESCE_EN
  assign coal_s = !empty_s && (addr_q[youngest_s] == st_addr) && !last_pop_s;
`else
  assign coal_s = 1'b0;
`endif

  assign st_ready = (state_q == FSM_IDLE) && (!full_s || coal_s);
  assign acc_s    = st_valid && st_ready;
  assign alloc_s  = acc_s && !coal_s;
  assign merge_s  = acc_s && coal_s;

  // Next-state of the entry array, pointers and occupancy.
  always_comb begin
    valid_d = valid_q;
    addr_d  = addr_q;
    data_d  = data_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (pop_s) begin
      valid_d[head_q] = 1'b0;
      head_d          = head_q + IDX_W'(1);
    end else begin
      head_d = head_q;
    end
    if (alloc_s) begin
      valid_d[tail_q] = 1'b1;
      addr_d[tail_q]  = st_addr;
      data_d[tail_q]  = st_data;
      tail_d          = tail_q + IDX_W'(1);
    end else if (merge_s) begin
      data_d[youngest_s] = st_data;
    end else begin
      tail_d = tail_q;
    end
    case ({alloc_s, pop_s})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Entry array and pointer registers; pending stores are dropped on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= {DEPTH{1'b0}};
      addr_q  <= {(DEPTH*ADDR_W){1'b0}};
      data_q  <= {(DEPTH*DATA_W){1'b0}};
      head_q  <= {IDX_W{1'b0}};
      tail_q  <= {IDX_W{1'b0}};
      count_q <= {CNT_W{1'b0}};
    end else begin
      valid_q <= valid_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Flush sequencing: DONE lasts exactly one cycle and ignores flush_req.
  always_comb begin
    state_d = state_q;
    case (state_q)
      FSM_IDLE: begin
        if (flush_req) state_d = FSM_DRAIN;
        else           state_d = FSM_IDLE;
      end
      FSM_DRAIN: begin
        if (empty_s || last_pop_s) state_d = FSM_DONE;
        else                       state_d = FSM_DRAIN;
      end
      FSM_DONE: state_d = FSM_IDLE;
      default:  state_d = FSM_IDLE;
    endcase
  end

  // Flush FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FSM_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  stbuf_match #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_match (
    .valid_i   (valid_q),
    .addr_i    (addr_q),
    .tail_i    (tail_q),
    .ld_addr_i (ld_addr),
    .hit_o     (hit_s),
    .idx_o     (hit_idx_s)
  );

  assign ld_hit       = ld_valid && hit_s;
  assign ld_data      = ld_hit ? data_q[hit_idx_s] : {DATA_W{1'b0}};
  assign mem_wr_valid = !empty_s;
  assign mem_wr_addr  = addr_q[head_q];
  assign mem_wr_data  = data_q[head_q];
  assign flush_done   = (state_q == FSM_DONE);
  assign empty        = empty_s;
  assign count        = count_q;

endmodule

// File: tb/tb_store_buffer_fwd.sv
// Scoreboard bench for store_buffer_fwd (DEPTH=4); expectations follow STBUF_COALESCE_EN when defined.
module tb_store_buffer_fwd;

  localparam int DW = 32;
  localparam int AW = 32;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          st_valid = 1'b0;
  logic [AW-1:0] st_addr = '0;
  logic [DW-1:0] st_data = '0;
  logic          st_ready;
  logic          ld_valid = 1'b0;
  logic [AW-1:0] ld_addr = '0;
  logic          ld_hit;
  logic [DW-1:0] ld_data;
  logic          mem_wr_valid;
  logic [AW-1:0] mem_wr_addr;
  logic [DW-1:0] mem_wr_data;
  logic          mem_wr_ready = 1'b0;
  logic          flush_req = 1'b0;
  logic          flush_done;
  logic          empty;
  logic [2:0]    count;

  int vectors = 0;
  int miscompares = 0;
  int n_pops = 0;
  logic [63:0] sb[$];
  logic pop_m, coal_m;

  store_buffer_fwd #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data), .st_ready(st_ready),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_hit(ld_hit), .ld_data(ld_data),
    .mem_wr_valid(mem_wr_valid), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
    .mem_wr_ready(mem_wr_ready), .flush_req(flush_req), .flush_done(flush_done),
    .empty(empty), .count(count)
  );

  always #5 clk = ~clk;

  // Scoreboard: record accepted stores, compare every memory write in order.
  always @(negedge clk) begin
    if (!rst_n) begin
      sb.delete();
    end else begin
      pop_m = mem_wr_valid && mem_wr_ready;
      if (pop_m) begin
        vectors++;
        n_pops++;
        if (sb.size() == 0) begin
          miscompares++;
          $display("FAIL mem_wr_unexpected got addr=%h data=%h with nothing expected", mem_wr_addr, mem_wr_data);
        end else if ({mem_wr_addr, mem_wr_data} !== sb[0]) begin
          miscompares++;
          $display("FAIL mem_wr_order got addr=%h data=%h expected addr=%h data=%h",
                   mem_wr_addr, mem_wr_data, sb[0][63:32], sb[0][31:0]);
        end
      end
      if (st_valid && st_ready) begin
        coal_m = 1'b0;
`ifdef STBUF_COALESCE_EN
        if (sb.size() > 0 && sb[sb.size()-1][63:32] == st_addr && !(sb.size() == 1 && pop_m))
          coal_m = 1'b1;
`endif
        if (coal_m) sb[sb.size()-1] = {st_addr, st_data};
        else        sb.push_back({st_addr, st_data});
      end
      if (pop_m && sb.size() > 0) void'(sb.pop_front());
    end
  end

  task automatic push_store(input logic [AW-1:0] a, input logic [DW-1:0] d);
    int g;
    g = 0;
    st_valid = 1'b1; st_addr = a; st_data = d;
    @(negedge clk);
    while (!st_ready && g < 40) begin
      @(negedge clk);
      g++;
    end
    vectors++;
    if (!st_ready) begin
      miscompares++;
      $display("FAIL push_accept addr=%h st_ready=%b expected 1", a, st_ready);
    end
    @(posedge clk); #1;
    st_valid = 1'b0;
  endtask

  task automatic drain();
    int g;
    g = 0;
    mem_wr_ready = 1'b1;
    @(negedge clk);
    while (!empty && g < 40) begin
      @(negedge clk);
      g++;
    end
    vectors++;
    if (!empty) begin
      miscompares++;
      $display("FAIL drain_timeout count=%0d expected 0", count);
    end
    @(posedge clk); #1;
    mem_wr_ready = 1'b0;
  endtask

  task automatic test_reset();
    ld_valid = 1'b1; ld_addr = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    vectors++;
    if ({st_ready, mem_wr_valid, ld_hit, flush_done, empty} !== 5'b10001 || ld_data !== 32'h0 || count !== 3'd0) begin
      miscompares++;
      $display("FAIL reset_values got rdy/wv/hit/done/empty=%b ld_data=%h count=%0d expected 10001 0 0",
               {st_ready, mem_wr_valid, ld_hit, flush_done, empty}, ld_data, count);
    end
    ld_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    push_store(32'h40, 32'h1111);
    push_store(32'h44, 32'h2222);
    mem_wr_ready = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if (count !== 3'd1) begin
      miscompares++;
      $display("FAIL reset_middrain_pre count=%0d expected 1", count);
    end
    rst_n = 1'b0;
    #1;
    vectors++;
    if (count !== 3'd0 || mem_wr_valid !== 1'b0 || st_ready !== 1'b1 || empty !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_middrain count=%0d wv=%b rdy=%b empty=%b expected 0 0 1 1",
               count, mem_wr_valid, st_ready, empty);
    end
    mem_wr_ready = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_fill();
    for (int i = 0; i < 4; i++) push_store(32'h100 + 32'(i * 4), 32'hA000 + 32'(i));
    @(negedge clk);
    vectors++;
    if (count !== 3'd4 || st_ready !== 1'b0 || mem_wr_addr !== 32'h100) begin
      miscompares++;
      $display("FAIL fill_full count=%0d rdy=%b head=%h expected 4 0 00000100", count, st_ready, mem_wr_addr);
    end
    @(posedge clk); #1;
    st_valid = 1'b1; st_addr = 32'h200; st_data = 32'hA5;
    repeat (2) begin
      @(negedge clk);
      vectors++;
      if (st_ready !== 1'b0 || count !== 3'd4) begin
        miscompares++;
        $display("FAIL fill_hold rdy=%b count=%0d expected 0 4", st_ready, count);
      end
      @(posedge clk); #1;
    end
    mem_wr_ready = 1'b1;
    @(negedge clk);
    vectors++;
    if (st_ready !== 1'b0 || mem_wr_addr !== 32'h100) begin
      miscompares++;
      $display("FAIL fill_pop_full rdy=%b head=%h expected 0 00000100", st_ready, mem_wr_addr);
    end
    @(posedge clk); #1;
    @(negedge clk);
    vectors++;
    if (st_ready !== 1'b1 || count !== 3'd3) begin
      miscompares++;
      $display("FAIL fill_after_pop rdy=%b count=%0d expected 1 3", st_ready, count);
    end
    @(posedge clk); #1;
    st_valid = 1'b0;
    drain();
  endtask

  task automatic test_forwarding();
    push_store(32'h10, 32'hAA);
    push_store(32'h10, 32'hBB);
    ld_valid = 1'b1; ld_addr = 32'h10;
    @(negedge clk);
    vectors++;
    if (ld_hit !== 1'b1 || ld_data !== 32'hBB) begin
      miscompares++;
      $display("FAIL fwd_youngest hit=%b data=%h expected 1 000000bb", ld_hit, ld_data);
    end
    @(posedge clk); #1;
    ld_addr = 32'h14;
    @(negedge clk);
    vectors++;
    if (ld_hit !== 1'b0 || ld_data !== 32'h0) begin
      miscompares++;
      $display("FAIL fwd_miss hit=%b data=%h expected 0 0", ld_hit, ld_data);
    end
    @(posedge clk); #1;
    ld_valid = 1'b0; ld_addr = 32'h10;
    @(negedge clk);
    vectors++;
    if (ld_hit !== 1'b0 || ld_data !== 32'h0) begin
      miscompares++;
      $display("FAIL fwd_ld_invalid hit=%b data=%h expected 0 0", ld_hit, ld_data);
    end
    @(posedge clk); #1;
    ld_valid = 1'b1; ld_addr = 32'h30;
    st_valid = 1'b1; st_addr = 32'h30; st_data = 32'hCC;
    @(negedge clk);
    vectors++;
    if (st_ready !== 1'b1 || ld_hit !== 1'b0) begin
      miscompares++;
      $display("FAIL fwd_same_cycle rdy=%b hit=%b expected 1 0", st_ready, ld_hit);
    end
    @(posedge clk); #1;
    st_valid = 1'b0;
    @(negedge clk);
    vectors++;
    if (ld_hit !== 1'b1 || ld_data !== 32'hCC) begin
      miscompares++;
      $display("FAIL fwd_next_cycle hit=%b data=%h expected 1 000000cc", ld_hit, ld_data);
    end
    @(posedge clk); #1;
    ld_valid = 1'b0;
    drain();
  endtask

  task automatic test_back_to_back();
    push_store(32'h300, 32'hB0);
    push_store(32'h304, 32'hB1);
    st_valid = 1'b1; mem_wr_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      st_addr = 32'h308 + 32'(i * 4); st_data = 32'hB2 + 32'(i);
      @(negedge clk);
      vectors++;
      if (count !== 3'd2 || st_ready !== 1'b1) begin
        miscompares++;
        $display("FAIL b2b_count iter=%0d count=%0d rdy=%b expected 2 1", i, count, st_ready);
      end
      @(posedge clk); #1;
    end
    st_valid = 1'b0; mem_wr_ready = 1'b0;
    @(negedge clk);
    vectors++;
    if (count !== 3'd2) begin
      miscompares++;
      $display("FAIL b2b_final count=%0d expected 2", count);
    end
    @(posedge clk); #1;
    drain();
  endtask

  task automatic test_flush();
    int pops0, dones;
    dones = 0;
    for (int i = 0; i < 3; i++) push_store(32'h500 + 32'(i * 4), 32'hF0 + 32'(i));
    pops0 = n_pops;
    flush_req = 1'b1;
    @(posedge clk); #1;
    st_valid = 1'b1; st_addr = 32'h5F0; st_data = 32'hFF;
    @(negedge clk);
    vectors++;
    if (st_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_block rdy=%b expected 0", st_ready);
    end
    @(posedge clk); #1;
    st_valid = 1'b0; mem_wr_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (flush_done) dones++;
      @(posedge clk); #1;
      if (dones > 0) flush_req = 1'b0;
    end
    mem_wr_ready = 1'b0;
    vectors++;
    if (dones !== 1 || (n_pops - pops0) !== 3) begin
      miscompares++;
      $display("FAIL flush_drain done_pulses=%0d writes=%0d expected 1 3", dones, n_pops - pops0);
    end
    @(negedge clk);
    vectors++;
    if (st_ready !== 1'b1 || empty !== 1'b1) begin
      miscompares++;
      $display("FAIL flush_idle rdy=%b empty=%b expected 1 1", st_ready, empty);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_flush_empty();
    logic [3:0] seen;
    flush_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      seen[i] = flush_done;
      @(posedge clk); #1;
      flush_req = 1'b0;
    end
    vectors++;
    if (seen !== 4'b0100) begin
      miscompares++;
      $display("FAIL flush_empty_timing done_by_cycle=%b expected 0100", seen);
    end
  endtask

  task automatic test_coalesce();
    logic [2:0] exp_cnt;
`ifdef STBUF_COALESCE_EN
    exp_cnt = 3'd1;
`else
    exp_cnt = 3'd2;
`endif
    push_store(32'h20, 32'h1);
    push_store(32'h20, 32'h2);
    @(negedge clk);
    vectors++;
    if (count !== exp_cnt) begin
      miscompares++;
      $display("FAIL coalesce_count count=%0d expected %0d", count, exp_cnt);
    end
    @(posedge clk); #1;
    drain();
  endtask

  initial begin
    test_reset();
    test_fill();
    test_forwarding();
    test_back_to_back();
    test_flush();
    test_flush_empty();
    test_coalesce();
    repeat (2) @(negedge clk);
    vectors++;
    if (sb.size() !== 0) begin
      miscompares++;
      $display("FAIL scoreboard_leftover pending=%0d expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
